// File: rtl/mem_bus_interface.sv
// mem_bus_interface
// Bridges the multi-cycle control unit's level-held MemRead/MemWrite
// requests to a registered req/ack handshake on the unified memory port.
// It captures read data, stalls the control unit through cpu_wait, and
// flags a bus error when memory does not acknowledge in time.
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   cpu_rd, cpu_wr           level requests, held until cpu_done
//   cpu_addr, cpu_wdata      request address and store data
//   cpu_rdata                registered read data (held between reads)
//   cpu_done                 one-cycle completion pulse
//   cpu_wait                 stall to the control unit
//   bus_err                  sticky error (timeout or rd+wr together)
//   mem_req, mem_we          registered request / write enable
//   mem_addr, mem_wdata      registered address / write data
//   mem_rdata, mem_ack       memory read data, one-cycle acknowledge
//   dbg_state                current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: mem_req rises on the edge that accepts a CPU request and stays
// high, with mem_we/mem_addr/mem_wdata frozen, until an edge that samples
// mem_ack=1 (or the timeout fires). mem_ack outside BUSY is ignored.

module mem_bus_interface #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_wait,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Last BUSY count value; the edge seeing it without an ack is the timeout.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cpu_rd | cpu_wr) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    // A simultaneous read and write is illegal: the write
                    // wins so memory sees a defined operation, and it is flagged.
                    we_d    = cpu_wr;
                    req_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                    if (cpu_rd & cpu_wr) begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Ack is tested first so an ack on the timeout edge still wins.
                if (mem_ack) begin
                    req_d  = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d  = 1'b1;
                    req_d  = 1'b0;
                    if (!we_q) begin
                        rdata_d = '1;
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                // Unconditional return: a request still held next cycle is new.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_done  = done_q;
    assign cpu_wait  = (cpu_rd | cpu_wr) & ~done_q;
    assign bus_err   = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_interface.sv
module tb_mem_bus_interface;

  localparam int TO = 8;

  logic        clk;
  logic        reset_n;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_wait;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // scoreboard entries: {bus_err, cpu_rdata} expected at each cpu_done
  logic [16:0] exp_q[$];
  logic [15:0] m_rdata;
  logic        m_err;

  mem_bus_interface #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_wait  (cpu_wait),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop on each completion pulse
  always @(negedge clk) begin
    if (reset_n && cpu_done) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        check_eq("sb_err_rdata", {15'd0, bus_err, cpu_rdata}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  // driver: called just after a negedge with the DUT in IDLE.
  // ack_at = BUSY cycle (1-based) carrying mem_ack; 0 or > TO means never.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int ack_at, input logic [15:0] rdata);
    logic timeout;
    int   end_c;
    int   req_cycles;
    logic done_seen;
    timeout = (ack_at < 1) || (ack_at > TO);
    end_c   = timeout ? TO : ack_at;
    if (rd & wr) m_err = 1'b1;
    if (timeout) m_err = 1'b1;
    if (!wr) m_rdata = timeout ? 16'hFFFF : rdata;
    exp_q.push_back({m_err, m_rdata});

    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;
    check_eq("wait_on_req", {31'd0, cpu_wait}, 32'd1);
    @(posedge clk);
    req_cycles = 0;
    done_seen  = 1'b0;
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_eq("mem_addr", {16'd0, mem_addr}, {16'd0, addr});
        check_eq("mem_we", {31'd0, mem_we}, {31'd0, wr});
        check_eq("mem_wdata", {16'd0, mem_wdata}, {16'd0, wdata});
        check_eq("state_busy", {30'd0, dbg_state}, 32'd1);
        // request inputs wander while BUSY; the latched copy must hold
        cpu_addr  = 16'($urandom);
        cpu_wdata = 16'($urandom);
      end
      if (mem_req) req_cycles++;
      if (cpu_done) begin
        done_seen = 1'b1;
        check_eq("done_cycle", c, end_c + 1);
        check_eq("req_cycles", req_cycles, end_c);
        check_eq("wait_at_done", {31'd0, cpu_wait}, 32'd0);
        check_eq("addr_hold", {16'd0, mem_addr}, {16'd0, addr});
        check_eq("wdata_hold", {16'd0, mem_wdata}, {16'd0, wdata});
        cpu_rd  = 1'b0;
        cpu_wr  = 1'b0;
        mem_ack = 1'b0;
      end else begin
        mem_ack   = (c == ack_at);
        mem_rdata = (c == ack_at) ? rdata : 16'($urandom);
      end
    end
    if (!done_seen) check_eq("done_bound", 32'd0, 32'd1);
    @(negedge clk);
    check_eq("done_one_cycle", {31'd0, cpu_done}, 32'd0);
    check_eq("req_low_idle", {31'd0, mem_req}, 32'd0);
    check_eq("state_idle", {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_addr  = 16'd0;
    cpu_wdata = 16'd0;
    mem_rdata = 16'd0;
    mem_ack   = 1'b0;
    m_rdata   = 16'd0;
    m_err     = 1'b0;
    #1;
    check_eq("rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_err", {31'd0, bus_err}, 32'd0);
    check_eq("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
    check_eq("rst_addr", {16'd0, mem_addr}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // read, ack on the first BUSY cycle
    run_txn(1'b1, 1'b0, 16'h0012, 16'h0000, 1, 16'hBEEF);
    // write with three wait cycles; read data must survive
    run_txn(1'b0, 1'b1, 16'h0040, 16'h1234, 4, 16'h0000);
    check_eq("rdata_after_write", {16'd0, cpu_rdata}, 32'h0000BEEF);
    // ack on the timeout edge wins
    run_txn(1'b1, 1'b0, 16'h0077, 16'h0000, TO, 16'h5A5A);
    // mixed traffic with random wait states
    for (int i = 0; i < 6; i++) begin
      logic w;
      w = 1'($urandom_range(0, 1));
      run_txn(~w, w, 16'($urandom), 16'($urandom), $urandom_range(1, TO - 1), 16'($urandom));
    end
    // timeout with no ack
    run_txn(1'b1, 1'b0, 16'h00FF, 16'h0000, 0, 16'h0000);
    check_eq("err_sticky_after_to", {31'd0, bus_err}, 32'd1);
    // error stays set across a clean transaction
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2, 16'hC0DE);

    // async reset in the middle of BUSY
    cpu_rd   = 1'b1;
    cpu_addr = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    check_eq("busy_before_rst", {31'd0, mem_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_req_async", {31'd0, mem_req}, 32'd0);
    check_eq("rst_done_async", {31'd0, cpu_done}, 32'd0);
    check_eq("rst_err_async", {31'd0, bus_err}, 32'd0);
    check_eq("rst_rdata_async", {16'd0, cpu_rdata}, 32'd0);
    m_err   = 1'b0;
    m_rdata = 16'd0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("no_resume", {31'd0, mem_req}, 32'd0);
    run_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 3, 16'hA55A);

    // read and write together: write wins, error flagged
    run_txn(1'b1, 1'b1, 16'h0003, 16'h9876, 2, 16'h1111);
    // stray ack while IDLE
    mem_ack   = 1'b1;
    mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("idle_ack_req", {31'd0, mem_req}, 32'd0);
    check_eq("idle_ack_done", {31'd0, cpu_done}, 32'd0);
    check_eq("idle_ack_rdata", {16'd0, cpu_rdata}, {16'd0, m_rdata});
    check_eq("idle_ack_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    check_eq("idle_ack_done2", {31'd0, cpu_done}, 32'd0);

    check_eq("sb_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_interface.md
Name: mem_bus_interface

Overview:
- Sits directly downstream of the multi-cycle control unit and datapath, between their MemRead/MemWrite/address/write-data signals and the single-port unified instruction/data memory.
- Converts level-held CPU memory requests into a registered req/ack handshake towards memory.
- Captures read data, produces a wait signal so the control unit can stall its current state, and detects bus timeouts.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 8, BUSY cycles without mem_ack before a bus error; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  MemRead from control unit; level, held until cpu_done.
- cpu_wr  in  1  MemWrite from control unit; level, held until cpu_done.
- cpu_addr  in  ADDR_W  address (PC or ALUOut, already muxed by AddrSel).
- cpu_wdata  in  DATA_W  store data (B register).
- cpu_rdata  out  DATA_W  registered read data to IR/MDR.
- cpu_done  out  1  one-cycle pulse: transaction complete.
- cpu_wait  out  1  combinational: (cpu_rd|cpu_wr) & ~cpu_done; control unit holds state while 1.
- bus_err  out  1  sticky error flag; cleared only by reset.
- mem_req  out  1  registered request to memory.
- mem_we  out  1  registered; 1 = write.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory acknowledge; one cycle per request.

Behaviour:
- Reset (async, reset_n=0): state IDLE; mem_req, mem_we, cpu_done and bus_err are 0; mem_addr, mem_wdata and cpu_rdata are 0; timeout counter is 0. mem_req drops immediately, including mid-transaction. No transaction resumes after reset release.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On an edge with cpu_rd|cpu_wr=1: latch cpu_addr into mem_addr and cpu_wdata into mem_wdata; set mem_we=cpu_wr and mem_req=1; clear the counter; go to BUSY.
  - If cpu_rd and cpu_wr are both 1: the write wins and bus_err is set. The transaction still completes.
  - mem_ack in IDLE or DONE is ignored.
- BUSY:
  - mem_req stays 1 and all mem_* outputs stay stable.
  - mem_ack=1 at an edge: mem_req goes to 0; if mem_we=0, cpu_rdata <= mem_rdata; cpu_done goes to 1; go to DONE.
  - No ack: the counter increments. If the counter equals TIMEOUT-1 at the edge and there is no ack: set bus_err, drop mem_req, cpu_rdata <= all ones (reads only), cpu_done goes to 1, go to DONE.
  - Ack on the same edge as the timeout: the ack wins; no error, normal data captured.
- DONE:
  - cpu_done is high for exactly this one cycle; it returns to 0 on the next edge.
  - Next state is IDLE regardless of inputs. A request still held in the following cycle is treated as a new transaction, so the control unit must advance state on cpu_done.
- Latency: request sampled at edge 0, mem_req high from edge 0, ack earliest sampled at edge 1, cpu_done high in cycle after edge 1. Minimum 2 cycles request-to-done; back-to-back throughput is one transaction per 3 cycles.
- Data hold: cpu_rdata keeps its last value until the next completed read; it is unchanged by writes.
- Request inputs changing while BUSY have no effect; the latched values are used.
- Address, data and counter arithmetic is unsigned with no wrap-around. The counter saturates at TIMEOUT-1 by construction.

Test Plan:
- Read, ack on first BUSY cycle: cpu_rd=1, cpu_addr=0x0012, mem_rdata=0xBEEF -> mem_req high for 1 cycle with mem_addr=0x0012 and mem_we=0; cpu_done pulses 2 cycles after request; cpu_rdata=0xBEEF; cpu_wait falls with cpu_done.
- Write with 3 wait cycles: cpu_wr=1, cpu_addr=0x0040, cpu_wdata=0x1234, ack on 4th BUSY cycle -> mem_we=1 and mem_wdata=0x1234 stable for 4 cycles; cpu_done 1 cycle; cpu_rdata unchanged; bus_err=0.
- Timeout with TIMEOUT=8 and no ack: read of 0x00FF -> mem_req high exactly 8 cycles; bus_err=1 sticky; cpu_rdata=0xFFFF; cpu_done pulses once.
- Ack coincident with timeout edge (ack at 8th BUSY cycle) -> cpu_rdata=mem_rdata; bus_err stays 0.
- Async reset mid-BUSY: assert reset_n=0 between edges -> mem_req and cpu_done go to 0 immediately. After release with cpu_rd=1, a fresh transaction starts from IDLE.
- cpu_rd and cpu_wr both 1 at addr 0x0003 -> write performed (mem_we=1); bus_err=1; completion normal. A late mem_ack pulse in IDLE is ignored.
